ex_mem: RTL
===========

Name: ex_mem

Overview:
- Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX register.
- Consumes the ex_* operand and control outputs, computes the ALU result and registers it with the memory-stage controls toward MEM.
- Adds a valid/ready handshake and a flush, so downstream stalls and control-hazard squashes are handled here.
- Keeps an accepted-instruction counter for debug.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 32, width of accepted-instruction counter.

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  upstream holds a valid instruction.
- ex_ready  out  1  this stage can accept.
- flush  in  1  squash the held and incoming instruction.
- ex_final_a  in  XLEN  operand A.
- ex_final_b  in  XLEN  operand B.
- ex_alu_op  in  3  ALU operation.
- ex_sub  in  1  SUB for ADD op, arithmetic shift for SRL op.
- ex_slt_and_spin_off_signed  in  1  signed set-less-than.
- ex_slt_and_spin_off_unsigned  in  1  unsigned set-less-than.
- ex_word_op  in  1  32-bit W-form operation.
- ex_is_write_dmem  in  1  store.
- ex_wb_select  in  2  writeback source.
- ex_write_width  in  8  store byte mask.
- ex_dmem_write_data  in  XLEN  store data.
- mem_valid  out  1  output register valid.
- mem_ready  in  1  MEM accepts.
- mem_alu_result  out  XLEN  registered ALU result.
- mem_is_write_dmem  out  1  registered; forced 0 when mem_valid=0.
- mem_wb_select  out  2  registered.
- mem_write_width  out  8  registered; forced 0 when mem_valid=0.
- mem_dmem_write_data  out  XLEN  registered.
- ex_accept_cnt  out  CNT_W  count of accepted instructions.

Behaviour:
- Reset (async, sys_rst=1): mem_valid=0, mem_alu_result=0, mem_is_write_dmem=0, mem_wb_select=0, mem_write_width=0, mem_dmem_write_data=0, ex_accept_cnt=0. Reset mid-transfer drops the held instruction.
- ALU is combinational from the ex_* inputs.
- ALU operation codes:
  - 000: ADD; SUB when ex_sub=1.
  - 001: SLL.
  - 010: XOR.
  - 011: OR.
  - 100: AND.
  - 101: SRL; SRA when ex_sub=1.
  - 110: result 0.
  - 111: pass B.
- SLT override: slt_signed=1 gives result = (signed a < signed b); else slt_unsigned=1 gives unsigned compare. The result is zero-extended to XLEN. Signed takes priority when both are set.
- Shift amount: b[5:0]; b[4:0] when ex_word_op=1.
- Word op: operate on a[31:0] and b[31:0]; SRA/SRL use a[31:0] only. The 32-bit result is sign-extended from bit 31. The SLT override ignores word_op.
- Arithmetic wraps modulo 2^XLEN, or 2^32 for word ops.
- Handshake:
  - ex_ready = !mem_valid || mem_ready (combinational).
  - Accept when ex_valid && ex_ready && !flush. On accept, all mem_* registers load on the next edge and mem_valid=1.
  - mem_valid && mem_ready && no accept: mem_valid drops to 0 the next cycle.
  - mem_valid && !mem_ready: all mem_* hold stable.
  - Simultaneous drain and accept: the new instruction replaces the old one with no bubble, and mem_valid stays 1.
- Flush: on the next edge mem_valid=0 and the incoming instruction is discarded. Flush overrides accept and stall, and the counter does not increment.
- Output gating: mem_is_write_dmem and mem_write_width must read 0 whenever mem_valid=0, so no spurious store reaches memory.
- ex_accept_cnt: +1 per accept; wraps at 2^CNT_W-1 back to 0.
- Latency: 1 cycle from accept to mem_valid.

Test Plan:
- Reset asserted mid-stream -> all outputs 0 immediately (async); ex_ready=1 after release.
- a=5, b=7, op=000, sub=1, accepted -> next cycle mem_alu_result=0xFFFF_FFFF_FFFF_FFFE, mem_valid=1.
- a=0x0000_0000_7FFF_FFFF, b=1, op=000, word_op=1 -> 0xFFFF_FFFF_8000_0000. Then a=0x8000_0000_0000_0000, b=1, slt_signed=1 -> 1; slt_unsigned=1 -> 0.
- a=0xFFFF_FFFF_8000_0000, b=4, op=101, sub=1, word_op=1 -> 0xFFFF_FFFF_F800_0000. Same with sub=0 -> 0x0000_0000_0800_0000.
- Back-to-back stream with mem_ready held 0 for 3 cycles -> ex_ready=0, outputs stable, no loss or duplication. With mem_ready=1 -> one result per cycle and the counter equals the number of instructions.
- Store held with mem_ready=0, flush pulsed with ex_valid=1 -> mem_valid=0, mem_is_write_dmem=0 and mem_write_width=0 next cycle; counter unchanged.

Source files
------------

// File: rtl/ex_mem.sv
// Execute stage (ALU) plus EX/MEM pipeline register with valid/ready handshake,
// flush, store-control gating and an accepted-instruction debug counter.
module ex_mem #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             flush,
    input  logic [XLEN-1:0]  ex_final_a,
    input  logic [XLEN-1:0]  ex_final_b,
    input  logic [2:0]       ex_alu_op,
    input  logic             ex_sub,
    input  logic             ex_slt_and_spin_off_signed,
    input  logic             ex_slt_and_spin_off_unsigned,
    input  logic             ex_word_op,
    input  logic             ex_is_write_dmem,
    input  logic [1:0]       ex_wb_select,
    input  logic [7:0]       ex_write_width,
    input  logic [XLEN-1:0]  ex_dmem_write_data,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [XLEN-1:0]  mem_alu_result,
    output logic             mem_is_write_dmem,
    output logic [1:0]       mem_wb_select,
    output logic [7:0]       mem_write_width,
    output logic [XLEN-1:0]  mem_dmem_write_data,
    output logic [CNT_W-1:0] ex_accept_cnt
);

    logic [5:0]      shamt;
    logic [31:0]     a_w;
    logic [31:0]     b_w;
    logic [31:0]     res_w;
    logic [XLEN-1:0] res_full;
    logic [XLEN-1:0] alu_result;

    always_comb begin
        a_w      = ex_final_a[31:0];
        b_w      = ex_final_b[31:0];
        shamt    = ex_word_op ? {1'b0, ex_final_b[4:0]} : ex_final_b[5:0];
        res_full = '0;
        res_w    = '0;
        case (ex_alu_op)
            3'b000: begin
                if (ex_sub) begin
                    res_full = ex_final_a - ex_final_b;
                    res_w    = a_w - b_w;
                end else begin
                    res_full = ex_final_a + ex_final_b;
                    res_w    = a_w + b_w;
                end
            end
            3'b001: begin
                res_full = ex_final_a << shamt;
                res_w    = a_w << shamt[4:0];
            end
            3'b010: begin
                res_full = ex_final_a ^ ex_final_b;
                res_w    = a_w ^ b_w;
            end
            3'b011: begin
                res_full = ex_final_a | ex_final_b;
                res_w    = a_w | b_w;
            end
            3'b100: begin
                res_full = ex_final_a & ex_final_b;
                res_w    = a_w & b_w;
            end
            3'b101: begin
                // Separate statements keep the arithmetic shift operand signed.
                if (ex_sub) begin
                    res_full = $signed(ex_final_a) >>> shamt;
                    res_w    = $signed(a_w) >>> shamt[4:0];
                end else begin
                    res_full = ex_final_a >> shamt;
                    res_w    = a_w >> shamt[4:0];
                end
            end
            3'b110: begin
                res_full = '0;
                res_w    = '0;
            end
            default: begin
                res_full = ex_final_b;
                res_w    = b_w;
            end
        endcase

        alu_result = ex_word_op ? {{(XLEN-32){res_w[31]}}, res_w} : res_full;

        // Set-less-than always compares the full-width operands.
        if (ex_slt_and_spin_off_signed) begin
            alu_result = {{(XLEN-1){1'b0}}, ($signed(ex_final_a) < $signed(ex_final_b))};
        end else if (ex_slt_and_spin_off_unsigned) begin
            alu_result = {{(XLEN-1){1'b0}}, (ex_final_a < ex_final_b)};
        end
    end

    logic             valid_q,  valid_d;
    logic [XLEN-1:0]  alu_q,    alu_d;
    logic             wr_q,     wr_d;
    logic [1:0]       wb_q,     wb_d;
    logic [7:0]       width_q,  width_d;
    logic [XLEN-1:0]  data_q,   data_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             accept;

    always_comb begin
        ex_ready = !valid_q || mem_ready;
        accept   = ex_valid && ex_ready && !flush;

        valid_d  = accept || (valid_q && !mem_ready);
        if (flush) begin
            valid_d = 1'b0;
        end

        alu_d    = alu_q;
        wr_d     = wr_q;
        wb_d     = wb_q;
        width_d  = width_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        if (accept) begin
            alu_d   = alu_result;
            wr_d    = ex_is_write_dmem;
            wb_d    = ex_wb_select;
            width_d = ex_write_width;
            data_d  = ex_dmem_write_data;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            wr_q    <= 1'b0;
            wb_q    <= '0;
            width_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            wr_q    <= wr_d;
            wb_q    <= wb_d;
            width_q <= width_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store controls are gated so a stale register never looks like a store.
    assign mem_valid           = valid_q;
    assign mem_alu_result      = alu_q;
    assign mem_is_write_dmem   = valid_q && wr_q;
    assign mem_wb_select       = wb_q;
    assign mem_write_width     = valid_q ? width_q : 8'h00;
    assign mem_dmem_write_data = data_q;
    assign ex_accept_cnt       = cnt_q;

endmodule
